// File: rtl/xxv_ts_tag_tracker.sv
// Two-step PTP TX timestamp tag tracker: tags requests, emits {tag,op} control words,
// matches returned timestamps against the oldest outstanding tag, and retires stale tags.
module xxv_ts_tag_tracker #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic        i_tx_eth_clk,
  input  logic        i_tx_eth_rst,
  input  logic        i_req_valid,
  input  logic [1:0]  i_req_op,
  output logic        o_req_ready,
  output logic [31:0] o_tx_ptp_ctrl_tdata,
  output logic        o_tx_ptp_ctrl_tvalid,
  output logic        o_tx_ptp_ctrl_tlast,
  input  logic        i_tx_ptp_ctrl_tready,
  input  logic [95:0] i_tx_ptp_ts_tdata,
  input  logic        i_tx_ptp_ts_tvalid,
  input  logic        i_tx_ptp_ts_tlast,
  output logic        o_tx_ptp_ts_tready,
  output logic [95:0] o_res_tdata,
  output logic        o_res_tuser,
  output logic        o_res_tvalid,
  input  logic        i_res_tready,
  output logic [6:0]  o_outstanding,
  output logic [15:0] o_stat_unmatched_cnt,
  output logic [15:0] o_stat_timeout_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e        r_state, w_state_d;
  logic [15:0]   r_tag;
  logic [31:0]   r_ctrl_tdata;
  logic          r_ctrl_tvalid;
  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [6:0]    r_count;
  logic [TW-1:0] r_timer;
  logic [95:0]   r_res_tdata;
  logic          r_res_tuser;
  logic          r_res_tvalid;
  logic [15:0]   r_unmatched_cnt;
  logic [15:0]   r_timeout_cnt;

  logic          w_req_ready, w_accept, w_ctrl_done, w_push, w_pop;
  logic          w_empty, w_res_free, w_ts_acc, w_match, w_drop, w_timeout;
  logic [15:0]   w_head;
  logic          w_unused_tlast;

  // Every ts beat is a full record, so tlast carries no information.
  assign w_unused_tlast = i_tx_ptp_ts_tlast;

  assign w_empty    = (r_count == 7'd0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_res_free = ~r_res_tvalid | i_res_tready;
  assign w_ts_acc   = i_tx_ptp_ts_tvalid & w_res_free;
  assign w_match    = w_ts_acc & ~w_empty & (i_tx_ptp_ts_tdata[95:80] == w_head);
  assign w_drop     = w_ts_acc & ~w_match;
  // A matching beat takes priority over a timeout in the same cycle.
  assign w_timeout  = ~w_empty & (r_timer == TMAX) & w_res_free & ~w_match;
  assign w_pop      = w_match | w_timeout;
  assign w_push     = w_ctrl_done & (r_ctrl_tdata[1:0] != 2'd0);

  // Issue FSM state register.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst) r_state <= StIdle;
    else              r_state <= w_state_d;
  end

  // Issue FSM next-state and handshake decode.
  always_comb begin
    w_state_d   = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_ctrl_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_ready = (r_count < DEPTH_C);
        if (i_req_valid && w_req_ready) begin
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (r_ctrl_tvalid && i_tx_ptp_ctrl_tready) begin
          w_ctrl_done = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Control word register and tag allocator.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst) begin
      r_tag         <= 16'd0;
      r_ctrl_tdata  <= 32'd0;
      r_ctrl_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_ctrl_tdata  <= {r_tag, 14'd0, i_req_op};
      r_ctrl_tvalid <= 1'b1;
      r_tag         <= r_tag + 16'd1;
    end else if (w_ctrl_done) begin
      r_ctrl_tvalid <= 1'b0;
    end
  end

  // Outstanding-tag FIFO storage; contents are don't-care when not counted.
  always_ff @(posedge i_tx_eth_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_ctrl_tdata[31:16];
  end

  // Outstanding-tag FIFO pointers and occupancy.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 7'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-queue age timer; saturates at TMAX while the result register is busy.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst || w_empty || w_pop) r_timer <= '0;
    else if (r_timer != TMAX)            r_timer <= r_timer + 1'b1;
  end

  // Result register: matched timestamp or zero-timestamp timeout record.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst) begin
      r_res_tdata  <= 96'd0;
      r_res_tuser  <= 1'b0;
      r_res_tvalid <= 1'b0;
    end else if (w_match) begin
      r_res_tdata  <= i_tx_ptp_ts_tdata;
      r_res_tuser  <= 1'b0;
      r_res_tvalid <= 1'b1;
    end else if (w_timeout) begin
      r_res_tdata  <= {w_head, 80'd0};
      r_res_tuser  <= 1'b1;
      r_res_tvalid <= 1'b1;
    end else if (i_res_tready) begin
      r_res_tvalid <= 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge i_tx_eth_clk) begin
    if (i_tx_eth_rst) begin
      r_unmatched_cnt <= 16'd0;
      r_timeout_cnt   <= 16'd0;
    end else begin
      if (w_drop && r_unmatched_cnt != 16'hffff)  r_unmatched_cnt <= r_unmatched_cnt + 16'd1;
      if (w_timeout && r_timeout_cnt != 16'hffff) r_timeout_cnt   <= r_timeout_cnt + 16'd1;
    end
  end

  assign o_req_ready          = w_req_ready;
  assign o_tx_ptp_ctrl_tdata  = r_ctrl_tdata;
  assign o_tx_ptp_ctrl_tvalid = r_ctrl_tvalid;
  assign o_tx_ptp_ctrl_tlast  = r_ctrl_tvalid;
  assign o_tx_ptp_ts_tready   = w_res_free;
  assign o_res_tdata          = r_res_tdata;
  assign o_res_tuser          = r_res_tuser;
  assign o_res_tvalid         = r_res_tvalid;
  assign o_outstanding        = r_count;
  assign o_stat_unmatched_cnt = r_unmatched_cnt;
  assign o_stat_timeout_cnt   = r_timeout_cnt;

endmodule

// File: tb/tb_xxv_ts_tag_tracker.sv
// Directed bench for xxv_ts_tag_tracker with a result scoreboard (DEPTH=4, TIMEOUT=16).
module tb_xxv_ts_tag_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic        req_ready;
  logic [31:0] ctrl_tdata;
  logic        ctrl_tvalid, ctrl_tlast;
  logic        ctrl_tready = 1'b1;
  logic [95:0] ts_tdata = 96'd0;
  logic        ts_tvalid = 1'b0;
  logic        ts_tlast = 1'b1;
  logic        ts_tready;
  logic [95:0] res_tdata;
  logic        res_tuser, res_tvalid;
  logic        res_tready = 1'b1;
  logic [6:0]  outstanding;
  logic [15:0] stat_unmatched, stat_timeout;

  int n_checks = 0;
  int n_errors = 0;
  logic [96:0] sb_q [$];

  xxv_ts_tag_tracker #(.DEPTH(4), .TIMEOUT(16)) dut (
    .i_tx_eth_clk         (clk),
    .i_tx_eth_rst         (rst),
    .i_req_valid          (req_valid),
    .i_req_op             (req_op),
    .o_req_ready          (req_ready),
    .o_tx_ptp_ctrl_tdata  (ctrl_tdata),
    .o_tx_ptp_ctrl_tvalid (ctrl_tvalid),
    .o_tx_ptp_ctrl_tlast  (ctrl_tlast),
    .i_tx_ptp_ctrl_tready (ctrl_tready),
    .i_tx_ptp_ts_tdata    (ts_tdata),
    .i_tx_ptp_ts_tvalid   (ts_tvalid),
    .i_tx_ptp_ts_tlast    (ts_tlast),
    .o_tx_ptp_ts_tready   (ts_tready),
    .o_res_tdata          (res_tdata),
    .o_res_tuser          (res_tuser),
    .o_res_tvalid         (res_tvalid),
    .i_res_tready         (res_tready),
    .o_outstanding        (outstanding),
    .o_stat_unmatched_cnt (stat_unmatched),
    .o_stat_timeout_cnt   (stat_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard: every completed result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && res_tvalid && res_tready) begin
      check("result_queued", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) check("result", {res_tuser, res_tdata}, sb_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] op);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    for (int i = 0; i < 64 && !done; i++) begin
      if (req_ready) done = 1'b1;
      tick(1);
    end
    req_valid = 1'b0;
    check("req_accept", 128'(done), 128'd1);
  endtask

  task automatic send_ts(input logic [15:0] tag, input logic [79:0] ts);
    bit done = 1'b0;
    ts_tvalid = 1'b1;
    ts_tdata  = {tag, ts};
    for (int i = 0; i < 64 && !done; i++) begin
      if (ts_tready) done = 1'b1;
      tick(1);
    end
    ts_tvalid = 1'b0;
    check("ts_accept", 128'(done), 128'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
    check(name, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    int n;
    int seen;
    tick(1);
    do_reset();

    // Reset state
    check("rst_req_ready", 128'(req_ready), 128'd1);
    check("rst_ctrl_tvalid", 128'(ctrl_tvalid), 128'd0);
    check("rst_ctrl_tdata", 128'(ctrl_tdata), 128'd0);
    check("rst_res_tvalid", 128'(res_tvalid), 128'd0);
    check("rst_outstanding", 128'(outstanding), 128'd0);
    check("rst_stats", 128'({stat_unmatched, stat_timeout}), 128'd0);

    // 1: op=2 with ctrl back-pressure, then matching ts
    ctrl_tready = 1'b0;
    send_req(2'd2);
    for (int i = 0; i < 4; i++) begin
      check("t1_ctrl_tvalid", 128'(ctrl_tvalid), 128'd1);
      check("t1_ctrl_tlast", 128'(ctrl_tlast), 128'd1);
      check("t1_ctrl_tdata", 128'(ctrl_tdata), 128'h0000_0002);
      check("t1_req_ready_busy", 128'(req_ready), 128'd0);
      if (i == 3) ctrl_tready = 1'b1;
      tick(1);
    end
    check("t1_ctrl_done", 128'(ctrl_tvalid), 128'd0);
    check("t1_outstanding_1", 128'(outstanding), 128'd1);
    sb_q.push_back({1'b0, 16'h0000, 80'h1234});
    send_ts(16'h0000, 80'h1234);
    check("t1_outstanding_0", 128'(outstanding), 128'd0);
    drain("t1_drain");

    // 2: NOOP consumes tag 1, never tracked
    send_req(2'd0);
    check("t2_ctrl_tdata", 128'(ctrl_tdata), 128'h0001_0000);
    check("t2_ctrl_tvalid", 128'(ctrl_tvalid), 128'd1);
    tick(1);
    check("t2_outstanding", 128'(outstanding), 128'd0);
    tick(30);
    check("t2_no_timeout", 128'(stat_timeout), 128'd0);

    // 3: fill to DEPTH, then free one slot
    do_reset();
    for (int i = 0; i < 4; i++) send_req(2'd1);
    tick(2);
    check("t3_outstanding_full", 128'(outstanding), 128'd4);
    check("t3_req_ready_full", 128'(req_ready), 128'd0);
    sb_q.push_back({1'b0, 16'h0000, 80'hAA55});
    send_ts(16'h0000, 80'hAA55);
    check("t3_req_ready_freed", 128'(req_ready), 128'd1);
    check("t3_outstanding_3", 128'(outstanding), 128'd3);
    for (int t = 1; t < 4; t++) sb_q.push_back({1'b1, 16'(t), 80'd0});
    drain("t3_drain");
    check("t3_timeout_cnt", 128'(stat_timeout), 128'd3);

    // 4: single tag times out exactly TIMEOUT cycles after push
    do_reset();
    send_req(2'd1);
    tick(1);
    check("t4_pushed", 128'(outstanding), 128'd1);
    sb_q.push_back({1'b1, 16'h0000, 80'd0});
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick(1);
      if (res_tvalid) n = i;
    end
    check("t4_latency", 128'(n), 128'd16);
    tick(1);
    check("t4_timeout_cnt", 128'(stat_timeout), 128'd1);
    check("t4_outstanding", 128'(outstanding), 128'd0);
    drain("t4_drain");

    // 5: mismatched ts dropped, head retained, then match
    do_reset();
    for (int i = 0; i < 3; i++) send_req(2'd0);
    send_req(2'd1);
    tick(1);
    check("t5_outstanding_1", 128'(outstanding), 128'd1);
    send_ts(16'h0055, 80'h1111);
    check("t5_unmatched", 128'(stat_unmatched), 128'd1);
    check("t5_head_kept", 128'(outstanding), 128'd1);
    sb_q.push_back({1'b0, 16'h0003, 80'h0000_0000_0000_DEAD_BEEF});
    send_ts(16'h0003, 80'h0000_0000_0000_DEAD_BEEF);
    drain("t5_drain");
    check("t5_outstanding_0", 128'(outstanding), 128'd0);
    check("t5_unmatched_final", 128'(stat_unmatched), 128'd1);

    // 6: reset pulse discards outstanding tags
    do_reset();
    send_req(2'd1);
    send_req(2'd3);
    tick(2);
    check("t6_outstanding_2", 128'(outstanding), 128'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_outstanding_0", 128'(outstanding), 128'd0);
    check("t6_res_tvalid", 128'(res_tvalid), 128'd0);
    check("t6_ctrl_tvalid", 128'(ctrl_tvalid), 128'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_tvalid) seen++;
      tick(1);
    end
    check("t6_no_result", 128'(seen), 128'd0);
    send_req(2'd1);
    check("t6_tag_restart", 128'(ctrl_tdata), 128'h0000_0001);
    sb_q.push_back({1'b1, 16'h0000, 80'd0});
    drain("t6_drain");

    tick(5);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
